// File: rtl/etroc_pll_afc_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : etroc_pll_afc_engine_if
// Brief    : AFC control/status bundle between slow control, VCO and engine.
// Revision : 1.0
// ============================================================================
interface etroc_pll_afc_engine_if;
  logic       AFC_Start;
  logic       AFC_OverrideCtrl;
  logic [5:0] AFC_OverrideCtrl_val;
  logic       vco_div_pulse;
  logic [5:0] AFC_capCtrl;
  logic [5:0] AFC_calCap;
  logic       AFC_busy;
  logic       AFC_done;

  modport master (
    output AFC_Start, AFC_OverrideCtrl, AFC_OverrideCtrl_val, vco_div_pulse,
    input  AFC_capCtrl, AFC_calCap, AFC_busy, AFC_done
  );

  modport slave (
    input  AFC_Start, AFC_OverrideCtrl, AFC_OverrideCtrl_val, vco_div_pulse,
    output AFC_capCtrl, AFC_calCap, AFC_busy, AFC_done
  );
endinterface
`default_nettype wire

// File: rtl/etroc_pll_afc_engine.sv
`default_nettype none
// ============================================================================
// Module   : etroc_pll_afc_engine
// Brief    : Successive-approximation VCO cap-bank calibration for ETROC2 PLL.
// Revision : 1.0
// ============================================================================
module etroc_pll_afc_engine #(
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 64,
  parameter int CNT_W      = 10,
  parameter int TARGET_CNT = 512
) (
  input  wire logic              CLK40REF,
  input  wire logic              AFC_RST,
  etroc_pll_afc_engine_if.slave  afc
);

  localparam int c_MAX_CYC = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int c_CYC_W   = $clog2(c_MAX_CYC + 1);
  localparam logic [c_CYC_W-1:0] c_SETTLE_LAST = c_CYC_W'(SETTLE_CYC - 1);
  localparam logic [c_CYC_W-1:0] c_WINDOW_LAST = c_CYC_W'(WINDOW_CYC - 1);
  localparam logic [CNT_W:0]     c_TARGET      = (CNT_W + 1)'(TARGET_CNT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_DECIDE  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_start_q;
  logic [5:0]           r_trial;
  logic [5:0]           r_cal_cap;
  logic [2:0]           r_bit_idx;
  logic [c_CYC_W-1:0]   r_cyc;
  logic [CNT_W-1:0]     r_pulse_cnt;

  logic w_start_edge;
  logic w_ovr;
  logic w_keep;
  logic w_busy;
  logic w_done;
  logic w_launch;
  logic w_decide;
  logic w_finish;

  assign w_ovr        = afc.AFC_OverrideCtrl;
  assign w_start_edge = afc.AFC_Start & ~r_start_q;
  // Strictly greater: a count equal to the target clears the bit.
  assign w_keep       = {1'b0, r_pulse_cnt} > c_TARGET;

  always_ff @(posedge CLK40REF) begin
    if (AFC_RST) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Override in any busy state aborts; the trial/result updates are gated off.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_launch    = 1'b0;
    w_decide    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start_edge && !w_ovr) begin
          w_state_nxt = S_SETTLE;
          w_launch    = 1'b1;
        end
      end
      S_SETTLE: begin
        if (w_ovr)                        w_state_nxt = S_IDLE;
        else if (r_cyc == c_SETTLE_LAST)  w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (w_ovr)                        w_state_nxt = S_IDLE;
        else if (r_cyc == c_WINDOW_LAST)  w_state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        if (w_ovr) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_decide    = 1'b1;
          w_state_nxt = (r_bit_idx == 3'd0) ? S_DONE : S_SETTLE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_done      = ~w_ovr;
        w_finish    = ~w_ovr;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK40REF) begin
    if (AFC_RST) begin
      r_start_q   <= 1'b0;
      r_trial     <= 6'd0;
      r_cal_cap   <= 6'd0;
      r_bit_idx   <= 3'd0;
      r_cyc       <= '0;
      r_pulse_cnt <= '0;
    end else begin
      r_start_q <= afc.AFC_Start;

      if (w_launch) begin
        r_trial   <= 6'b100000;
        r_bit_idx <= 3'd5;
      end else if (w_decide) begin
        r_trial[r_bit_idx] <= w_keep;
        if (r_bit_idx != 3'd0) begin
          r_trial[r_bit_idx - 3'd1] <= 1'b1;
          r_bit_idx                 <= r_bit_idx - 3'd1;
        end
      end

      if (r_state != w_state_nxt)
        r_cyc <= '0;
      else if (r_state == S_SETTLE || r_state == S_MEASURE)
        r_cyc <= r_cyc + 1'b1;

      // Holding the counter clear through SETTLE gives a fresh window.
      if (r_state == S_SETTLE)
        r_pulse_cnt <= '0;
      else if (r_state == S_MEASURE && afc.vco_div_pulse && (r_pulse_cnt != '1))
        r_pulse_cnt <= r_pulse_cnt + 1'b1;

      if (w_finish) r_cal_cap <= r_trial;
    end
  end

  assign afc.AFC_capCtrl = w_ovr ? afc.AFC_OverrideCtrl_val : r_trial;
  assign afc.AFC_calCap  = r_cal_cap;
  assign afc.AFC_busy    = w_busy;
  assign afc.AFC_done    = w_done;

endmodule
`default_nettype wire

// File: tb/tb_etroc_pll_afc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_etroc_pll_afc_engine
// Brief    : Self-checking bench for the AFC engine with a behavioural VCO.
// Revision : 1.0
// ============================================================================
module tb_etroc_pll_afc_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  etroc_pll_afc_engine_if ifa();
  etroc_pll_afc_engine_if ifb();

  etroc_pll_afc_engine #(.TARGET_CNT(45)) dut_a (
    .CLK40REF (clk),
    .AFC_RST  (rst),
    .afc      (ifa.slave)
  );

  // Long window lets the 10-bit counter reach saturation.
  etroc_pll_afc_engine #(
    .SETTLE_CYC (2),
    .WINDOW_CYC (1100),
    .CNT_W      (10),
    .TARGET_CNT (512)
  ) dut_b (
    .CLK40REF (clk),
    .AFC_RST  (rst),
    .afc      (ifb.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [5:0] exp_cal_a;

  typedef struct {
    int         thresh;
    bit         noise;
    logic [5:0] exp_cal;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses per window a VCO would produce at a given code. thresh<0 selects the
  // linear VCO 90-code (rescaled so counts fit in a 64-cycle window).
  function automatic int vco_count(int thresh, logic [5:0] code, int hi, int lo);
    int n;
    if (thresh < 0) begin
      n = 90 - int'(code);
      if (n > 64) n = 64;
    end else begin
      n = (int'(code) < thresh) ? hi : lo;
    end
    return n;
  endfunction

  // SAR result = highest code still reading "too fast" (count > 45), else 0.
  function automatic logic [5:0] model_result(int thresh);
    int k = 0;
    for (int c = 0; c < 64; c++)
      if (vco_count(thresh, 6'(c), 64, 0) > 45) k++;
    return (k == 0) ? 6'd0 : 6'(k - 1);
  endfunction

  task automatic run_a(input int thresh, input bit noise, input int toggle_at,
                       input int abort_at, input int rst_at, input logic [5:0] exp_cal);
    int hi, lo, busy_cyc, done_cnt, o, b, n, held;
    logic [5:0] conv_seq[6];
    conv_seq = '{6'd32, 6'd48, 6'd40, 6'd44, 6'd46, 6'd45};
    hi = int'($urandom_range(64, 46));
    lo = int'($urandom_range(45, 0));
    busy_cyc = 0;
    done_cnt = 0;
    ifa.AFC_Start = 1'b0;
    tick(); tick();
    ifa.AFC_Start = 1'b1;
    tick();
    for (int k = 0; k <= 490; k++) begin
      if (ifa.AFC_busy) busy_cyc++;
      if (ifa.AFC_done) done_cnt++;
      o = k % 81;
      b = k / 81;
      if (k == 0)   chk("capctrl_at_start", ifa.AFC_capCtrl, 6'b100000);
      if (k == 486) chk("done_in_last_busy", {ifa.AFC_done, ifa.AFC_busy}, 2'b11);
      if (thresh < 0 && b < 6 && o == 16) chk("trial_seq", ifa.AFC_capCtrl, conv_seq[b]);
      if (k == toggle_at)     ifa.AFC_Start = 1'b0;
      if (k == toggle_at + 1) ifa.AFC_Start = 1'b1;
      if (k == toggle_at + 2) ifa.AFC_Start = 1'b0;
      if (k == toggle_at + 3) ifa.AFC_Start = 1'b1;
      if (k == abort_at) begin
        ifa.AFC_OverrideCtrl     = 1'b1;
        ifa.AFC_OverrideCtrl_val = 6'b010001;
        #1;
        chk("abort_capctrl_same_cycle", ifa.AFC_capCtrl, 6'b010001);
        ifa.vco_div_pulse = 1'b0;
        tick();
        chk("abort_busy_done", {ifa.AFC_busy, ifa.AFC_done}, 2'b00);
        chk("abort_calcap_kept", ifa.AFC_calCap, exp_cal_a);
        done_cnt = 0;
        for (int j = 0; j < 8; j++) begin
          if (ifa.AFC_done || ifa.AFC_busy) done_cnt++;
          tick();
        end
        chk("abort_stays_idle", done_cnt, 0);
        ifa.AFC_OverrideCtrl = 1'b0;
        #1;
        chk("abort_trial_kept", ifa.AFC_capCtrl, conv_seq[abort_at / 81]);
        ifa.AFC_Start = 1'b0;
        return;
      end
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_outputs", {ifa.AFC_busy, ifa.AFC_done, ifa.AFC_calCap, ifa.AFC_capCtrl},
            {2'b00, 6'd0, 6'd0});
        exp_cal_a = 6'd0;
        ifa.AFC_Start = 1'b0;
        return;
      end
      n = vco_count(thresh, ifa.AFC_capCtrl, hi, lo);
      if (b < 6 && o >= 16 && o < 80) ifa.vco_div_pulse = ((o - 16) < n);
      else                            ifa.vco_div_pulse = noise;
      tick();
    end
    ifa.vco_div_pulse = 1'b0;
    chk("busy_cycles", busy_cyc, 487);
    chk("done_pulses", done_cnt, 1);
    chk("calcap_result", ifa.AFC_calCap, exp_cal);
    exp_cal_a = exp_cal;
    held = 0;
    for (int j = 0; j < 10; j++) begin
      if (ifa.AFC_busy) held++;
      tick();
    end
    chk("start_held_no_retrigger", held, 0);
    ifa.AFC_Start = 1'b0;
  endtask

  task automatic run_b(input bit pulses_on, input logic [5:0] exp_cal);
    int busy_cyc = 0;
    int done_cnt = 0;
    int guard    = 0;
    ifb.vco_div_pulse = pulses_on;
    ifb.AFC_Start = 1'b0;
    tick(); tick();
    ifb.AFC_Start = 1'b1;
    tick();
    while (ifb.AFC_busy && guard < 8000) begin
      busy_cyc++;
      if (ifb.AFC_done) done_cnt++;
      guard++;
      tick();
    end
    chk("b_busy_cycles", busy_cyc, 6 * (2 + 1100 + 1) + 1);
    chk("b_done_pulses", done_cnt, 1);
    chk("b_calcap", ifb.AFC_calCap, exp_cal);
    ifb.AFC_Start = 1'b0;
    ifb.vco_div_pulse = 1'b0;
  endtask

  initial begin
    int t;
    rst = 1'b1;
    ifa.AFC_Start = 1'b0; ifa.AFC_OverrideCtrl = 1'b0; ifa.AFC_OverrideCtrl_val = 6'd0; ifa.vco_div_pulse = 1'b0;
    ifb.AFC_Start = 1'b0; ifb.AFC_OverrideCtrl = 1'b0; ifb.AFC_OverrideCtrl_val = 6'd0; ifb.vco_div_pulse = 1'b0;
    exp_cal_a = 6'd0;
    tick(); tick(); tick();
    chk("rst_a_outputs", {ifa.AFC_busy, ifa.AFC_done, ifa.AFC_calCap, ifa.AFC_capCtrl}, 14'd0);
    chk("rst_b_outputs", {ifb.AFC_busy, ifb.AFC_done, ifb.AFC_calCap, ifb.AFC_capCtrl}, 14'd0);
    ifa.AFC_OverrideCtrl = 1'b1;
    ifa.AFC_OverrideCtrl_val = 6'b111100;
    tick();
    chk("rst_override_capctrl", ifa.AFC_capCtrl, 6'b111100);
    ifa.AFC_OverrideCtrl = 1'b0;
    rst = 1'b0;
    tick();

    vecs[0] = '{-1, 1'b1, 6'd44};
    vecs[1] = '{64, 1'b1, 6'd63};
    vecs[2] = '{0,  1'b1, 6'd0};
    vecs[3] = '{1,  1'b0, 6'd0};
    vecs[4] = '{2,  1'b1, 6'd1};
    vecs[5] = '{33, 1'b0, 6'd32};
    vecs[6] = '{17, 1'b1, 6'd16};
    foreach (vecs[i]) run_a(vecs[i].thresh, vecs[i].noise, -1, -1, -1, vecs[i].exp_cal);

    for (int r = 0; r < 4; r++) begin
      t = int'($urandom_range(64, 0));
      run_a(t, 1'($urandom_range(1, 0)), -1, -1, -1, model_result(t));
    end

    run_a(-1, 1'b1, 100, -1, -1, 6'd44);
    run_a(-1, 1'b1, -1, 200, -1, 6'd44);
    run_a(-1, 1'b1, -1, -1, 300, 6'd44);
    run_a(-1, 1'b1, -1, -1, -1, 6'd44);

    // Start edge coincident with override must not launch a run.
    ifa.AFC_OverrideCtrl = 1'b1;
    ifa.AFC_Start = 1'b1;
    tick(); tick();
    chk("start_with_override_ignored", ifa.AFC_busy, 1'b0);
    ifa.AFC_OverrideCtrl = 1'b0;
    tick();
    chk("no_late_start_after_override", ifa.AFC_busy, 1'b0);
    ifa.AFC_Start = 1'b0;
    tick();

    run_b(1'b1, 6'd63);
    run_b(1'b0, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
